hazard_tracker: RTL and testbench

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_tracker_if.sv | 41 ++++
 rtl/hazard_tracker.sv | 111 +++++++++++
 tb/tb_hazard_tracker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_tracker_if.sv
// Decode-side inputs and hazard-control outputs of the pipeline hazard tracker.
// slave is the tracker; master is whoever drives Decode and consumes stall/flush.
interface hazard_tracker_if;
    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] WA3D;
    logic       RegWriteD;
    logic       MemtoRegD;
    logic       LongOpD;
    logic       BranchTakenE;

    logic       Match_1E_M;
    logic       Match_1E_W;
    logic       Match_2E_M;
    logic       Match_2E_W;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushD;
    logic       FlushE;

    // Debug view of the long-op FSM (busy flag and occupancy counter).
    logic       long_op_busy;
    logic [2:0] long_op_cnt;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, LongOpD, BranchTakenE,
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
        input  RegWriteM, RegWriteW, StallF, StallD, StallE, FlushD, FlushE,
        input  long_op_busy, long_op_cnt
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, LongOpD, BranchTakenE,
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W,
        output RegWriteM, RegWriteW, StallF, StallD, StallE, FlushD, FlushE,
        output long_op_busy, long_op_cnt
    );
endinterface

// File: rtl/hazard_tracker.sv
// Tracks E/M/W register usage for forwarding matches, load-use stalls, branch
// flushes and multi-cycle long ops that occupy Execute for MUL_CYCLES cycles.
module hazard_tracker #(
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    hazard_tracker_if.slave  hz
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] LAST = 3'(MUL_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;

    logic [3:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteE, MemtoRegE, LongOpE;
    logic       reg_write_m, reg_write_w;

    logic ld_stall;
    logic stall_e;
    logic flush_e;

    assign ld_stall = MemtoRegE & RegWriteE & ((hz.RA1D == WA3E) | (hz.RA2D == WA3E));
    assign stall_e  = ((state == IDLE) & LongOpE) | ((state == BUSY) & (cnt < LAST));
    // While Execute is held, a load-use hazard or taken branch must not disturb it.
    assign flush_e  = ~stall_e & (hz.BranchTakenE | ld_stall);

    assign hz.Match_1E_M   = (RA1E == WA3M);
    assign hz.Match_1E_W   = (RA1E == WA3W);
    assign hz.Match_2E_M   = (RA2E == WA3M);
    assign hz.Match_2E_W   = (RA2E == WA3W);
    assign hz.RegWriteM    = reg_write_m;
    assign hz.RegWriteW    = reg_write_w;
    assign hz.StallE       = stall_e;
    assign hz.StallF       = stall_e | ld_stall;
    assign hz.StallD       = stall_e | ld_stall;
    assign hz.FlushD       = ~stall_e & hz.BranchTakenE;
    assign hz.FlushE       = flush_e;
    assign hz.long_op_busy = (state == BUSY);
    assign hz.long_op_cnt  = cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            RA1E        <= '0;
            RA2E        <= '0;
            WA3E        <= '0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            LongOpE     <= 1'b0;
            WA3M        <= '0;
            reg_write_m <= 1'b0;
            WA3W        <= '0;
            reg_write_w <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LongOpE) begin
                        state <= BUSY;
                        cnt   <= 3'd1;
                    end
                end
                BUSY: begin
                    if (cnt < LAST) begin
                        cnt <= cnt + 3'd1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // Execute: hold under a long op, bubble on flush, otherwise take Decode.
            if (!stall_e) begin
                if (flush_e) begin
                    RA1E      <= '0;
                    RA2E      <= '0;
                    WA3E      <= '0;
                    RegWriteE <= 1'b0;
                    MemtoRegE <= 1'b0;
                    LongOpE   <= 1'b0;
                end else begin
                    RA1E      <= hz.RA1D;
                    RA2E      <= hz.RA2D;
                    WA3E      <= hz.WA3D;
                    RegWriteE <= hz.RegWriteD;
                    MemtoRegE <= hz.MemtoRegD;
                    LongOpE   <= hz.LongOpD;
                end
            end

            if (stall_e) begin
                WA3M        <= '0;
                reg_write_m <= 1'b0;
            end else begin
                WA3M        <= WA3E;
                reg_write_m <= RegWriteE;
            end

            WA3W        <= WA3M;
            reg_write_w <= reg_write_m;
        end
    end
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed scenarios plus randomized traffic for hazard_tracker, checked against
// an instruction-level model that tracks how long the op in Execute has been held.
module tb_hazard_tracker;
  localparam int MUL = 3;

  logic clk;
  logic reset;
  hazard_tracker_if ifc ();

  hazard_tracker #(.MUL_CYCLES(MUL)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (ifc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       rw;
    logic       mtr;
    logic       lng;
  } instr_t;

  instr_t     m_e;
  logic [3:0] m_wa3m, m_wa3w;
  logic       m_rwm, m_rww;
  int         m_age;   // cycles the instruction now in Execute has already been held

  function automatic logic m_stall_e();
    return m_e.lng && (m_age < MUL - 1);
  endfunction

  function automatic logic m_load_use();
    return m_e.mtr && m_e.rw && (ifc.RA1D == m_e.wa3 || ifc.RA2D == m_e.wa3);
  endfunction

  function automatic logic [14:0] m_vec();
    logic se, ld, br;
    se = m_stall_e();
    ld = m_load_use();
    br = ifc.BranchTakenE;
    return {m_e.ra1 == m_wa3m, m_e.ra1 == m_wa3w, m_e.ra2 == m_wa3m, m_e.ra2 == m_wa3w,
            m_rwm, m_rww, se || ld, se || ld, se,
            !se && br, !se && (br || ld), m_age != 0, 3'(m_age)};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {ifc.Match_1E_M, ifc.Match_1E_W, ifc.Match_2E_M, ifc.Match_2E_W,
            ifc.RegWriteM, ifc.RegWriteW, ifc.StallF, ifc.StallD, ifc.StallE,
            ifc.FlushD, ifc.FlushE, ifc.long_op_busy, ifc.long_op_cnt};
  endfunction

  task automatic model_step();
    logic   se, fe;
    instr_t d;
    se = m_stall_e();
    fe = !se && (ifc.BranchTakenE || m_load_use());
    d  = '{ifc.RA1D, ifc.RA2D, ifc.WA3D, ifc.RegWriteD, ifc.MemtoRegD, ifc.LongOpD};
    if (reset) begin
      m_e = '0; m_wa3m = '0; m_wa3w = '0; m_rwm = 1'b0; m_rww = 1'b0; m_age = 0;
    end else begin
      m_wa3w = m_wa3m;
      m_rww  = m_rwm;
      if (se) begin
        m_wa3m = '0;
        m_rwm  = 1'b0;
        m_age++;
      end else begin
        m_wa3m = m_e.wa3;
        m_rwm  = m_e.rw;
        m_age  = 0;
        m_e    = fe ? '0 : d;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [14:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Predict from the model, then compare the whole output vector.
  task automatic look(input string tag);
    logic [14:0] e;
    logic [14:0] o;
    #1;
    exp_q.push_back(m_vec());
    e = exp_q.pop_front();
    o = dut_vec();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic rw, input logic mtr, input logic lng, input logic br);
    ifc.RA1D = ra1;  ifc.RA2D = ra2;  ifc.WA3D = wa3;
    ifc.RegWriteD = rw;  ifc.MemtoRegD = mtr;  ifc.LongOpD = lng;
    ifc.BranchTakenE = br;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       hold;
    logic [3:0] r1, r2, w;
    logic       rw, mtr, lng, br;
    hold = 1'b0;
    r1 = '0; r2 = '0; w = '0; rw = 1'b0; mtr = 1'b0; lng = 1'b0;
    m_e = '0; m_wa3m = '0; m_wa3w = '0; m_rwm = 1'b0; m_rww = 1'b0; m_age = 0;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    look("reset");
    chk("rst_match_1e_m", ifc.Match_1E_M, 1'b1);
    chk("rst_match_2e_w", ifc.Match_2E_W, 1'b1);
    chk("rst_regwrite_m", ifc.RegWriteM, 1'b0);
    chk("rst_stall_e", ifc.StallE, 1'b0);
    chk("rst_flush_e", ifc.FlushE, 1'b0);

    // ADD R1 followed by a reader of R1
    drive(0, 0, 1, 1, 0, 0, 0); look("add_d"); tick();
    drive(1, 0, 0, 0, 0, 0, 0); look("use_d"); tick();
    look("use_e");
    chk("fwd_match_1e_m", ifc.Match_1E_M, 1'b1);
    chk("fwd_regwrite_m", ifc.RegWriteM, 1'b1);
    tick();
    look("use_w");
    chk("fwd_match_1e_w", ifc.Match_1E_W, 1'b1);
    chk("fwd_regwrite_w", ifc.RegWriteW, 1'b1);

    // LDR R2 followed by a reader of R2: one load-use stall
    drive(0, 0, 2, 1, 1, 0, 0); look("ldr_d"); tick();
    drive(0, 2, 0, 0, 0, 0, 0); look("ldr_hazard");
    chk("ld_stall_f", ifc.StallF, 1'b1);
    chk("ld_stall_d", ifc.StallD, 1'b1);
    chk("ld_flush_e", ifc.FlushE, 1'b1);
    chk("ld_flush_d", ifc.FlushD, 1'b0);
    tick();
    look("ldr_after");
    chk("ld_stall_once", ifc.StallF, 1'b0);
    chk("ld_flush_once", ifc.FlushE, 1'b0);
    tick();
    look("ldr_wb");
    chk("ld_match_2e_w", ifc.Match_2E_W, 1'b1);
    chk("ld_regwrite_w", ifc.RegWriteW, 1'b1);

    // Taken branch squashes a long op sitting in Decode
    drive(0, 0, 7, 1, 0, 1, 1); look("br");
    chk("br_flush_d", ifc.FlushD, 1'b1);
    chk("br_flush_e", ifc.FlushE, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); look("br_bubble");
    chk("br_bubble_no_long", ifc.StallE, 1'b0);
    tick();
    look("br_bubble_m");
    chk("br_bubble_regwrite_m", ifc.RegWriteM, 1'b0);

    // Long op holds Execute for MUL cycles
    drive(0, 0, 5, 1, 0, 1, 0); look("mul_d"); tick();
    drive(0, 0, 0, 0, 0, 0, 0); look("mul_1");
    chk("mul1_stall_e", ifc.StallE, 1'b1);
    chk("mul1_stall_f", ifc.StallF, 1'b1);
    chk("mul1_stall_d", ifc.StallD, 1'b1);
    chk("mul1_regwrite_m", ifc.RegWriteM, 1'b0);
    tick();
    look("mul_2");
    chk("mul2_stall_e", ifc.StallE, 1'b1);
    chk("mul2_regwrite_m", ifc.RegWriteM, 1'b0);
    tick();
    look("mul_3");
    chk("mul3_stall_e", ifc.StallE, 1'b0);
    chk("mul3_regwrite_m", ifc.RegWriteM, 1'b0);
    tick();
    look("mul_m");
    chk("mul_reaches_m", ifc.RegWriteM, 1'b1);

    // Branch while Execute is held by a long op is ignored
    drive(0, 0, 6, 1, 0, 1, 0); look("mulbr_d"); tick();
    drive(0, 0, 0, 0, 0, 0, 1); look("mulbr_br");
    chk("stall_br_flush_d", ifc.FlushD, 1'b0);
    chk("stall_br_flush_e", ifc.FlushE, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); look("mulbr_held");
    chk("stall_br_still_held", ifc.StallE, 1'b1);
    tick(); look("mulbr_last");
    tick(); look("mulbr_out");

    // Reset in the middle of a long op aborts it
    drive(0, 0, 9, 1, 0, 1, 0); look("abort_d"); tick();
    drive(0, 0, 0, 0, 0, 0, 0); look("abort_idle"); tick();
    look("abort_busy");
    chk("abort_busy_flag", ifc.long_op_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    look("abort_after");
    chk("abort_stall_e", ifc.StallE, 1'b0);
    chk("abort_regwrite_m", ifc.RegWriteM, 1'b0);
    chk("abort_regwrite_w", ifc.RegWriteW, 1'b0);
    chk("abort_fsm_idle", ifc.long_op_busy, 1'b0);

    // Randomized traffic; Decode is held steady whenever StallD is expected
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        r1  = 4'($urandom_range(0, 3));
        r2  = 4'($urandom_range(0, 3));
        w   = 4'($urandom_range(0, 3));
        rw  = ($urandom_range(0, 3) != 0);
        mtr = ($urandom_range(0, 2) == 0);
        lng = ($urandom_range(0, 4) == 0);
      end
      br    = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 99) == 0);
      drive(r1, r2, w, rw, mtr, lng, br);
      look("rand");
      hold = !reset && (m_stall_e() || m_load_use());
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    look("rand_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
